// File: rtl/prover_compute_v_pkg.sv
// Shared field package: arithmetic over the Mersenne prime F_Q = 2^61 - 1,
// plus the round-engine state type.
package prover_compute_v_pkg;

    localparam int F_NBITS = 61;
    localparam logic [F_NBITS-1:0] F_Q = {F_NBITS{1'b1}};

    typedef logic [F_NBITS-1:0] fe_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic fe_t f_add(input fe_t a, input fe_t b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
        return s[F_NBITS-1:0];
    endfunction

    function automatic fe_t f_sub(input fe_t a, input fe_t b);
        return (a >= b) ? (a - b) : (a + (F_Q - b));
    endfunction

    // 2^61 == 1 mod F_Q, so the product folds by adding its high and low halves.
    function automatic fe_t f_mul(input fe_t a, input fe_t b);
        logic [2*F_NBITS-1:0] p;
        logic [F_NBITS:0]     t;
        logic [F_NBITS:0]     u;
        p = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
        t = {1'b0, p[F_NBITS-1:0]} + {1'b0, p[2*F_NBITS-1:F_NBITS]};
        u = {1'b0, t[F_NBITS-1:0]} + {{F_NBITS{1'b0}}, t[F_NBITS]};
        if (u >= {1'b0, F_Q}) u = u - {1'b0, F_Q};
        return u[F_NBITS-1:0];
    endfunction

endpackage

// File: rtl/prover_compute_v_field_mul_add.sv
// field_mul_add: combinational y = (a*b + c*d) mod F_Q.
module field_mul_add
    import prover_compute_v_pkg::*;
(
    input  logic [F_NBITS-1:0] a,
    input  logic [F_NBITS-1:0] b,
    input  logic [F_NBITS-1:0] c,
    input  logic [F_NBITS-1:0] d,
    output logic [F_NBITS-1:0] y
);

    assign y = f_add(f_mul(a, b), f_mul(c, d));

endmodule

// File: rtl/prover_compute_v.sv
// prover_compute_v: sum-check round engine folding gate-value pairs with challenge tau.
// Optional macro PROVER_COMPUTE_V_SKIP012_EN: skip012 freezes v_0/v_1 for a round.
//
// state   | meaning
// ST_IDLE | waiting for en; ready high once a round has completed
// ST_RUN  | folding pair k_q, one pair per cycle
// ST_DONE | last pair written; raises ready/ready_pulse
module prover_compute_v
    import prover_compute_v_pkg::*;
#(
    parameter  int ngates     = 8,
    localparam int ngates_out = 1 << ($clog2(ngates) - 1)
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               en,
    input  logic               restart,
    input  logic               skip012,
    input  logic [F_NBITS-1:0] v_in     [ngates],
    input  logic [F_NBITS-1:0] tau,
    input  logic [F_NBITS-1:0] m_tau_p1,
    output logic               ready_pulse,
    output logic               ready,
    output logic [F_NBITS-1:0] v_0      [ngates_out],
    output logic [F_NBITS-1:0] v_1      [ngates_out],
    output logic [F_NBITS-1:0] v_tau    [ngates_out]
);

    localparam int KW     = (ngates_out > 1) ? $clog2(ngates_out) : 1;
    localparam int NW     = KW + 1;
    localparam int NWORDS = 2 * ngates_out;

    state_t             state_q, state_d;
    logic [F_NBITS-1:0] w         [NWORDS];
    logic [F_NBITS-1:0] w_restart [NWORDS];
    logic [F_NBITS-1:0] w_fold    [NWORDS];
    logic [F_NBITS-1:0] tau_q, mtau_q, pair_tau;
    logic [KW-1:0]      k_q;
    logic [NW-1:0]      n_q, n_start;
    logic               start, last, skip_q, skip_start;

    for (genvar i = 0; i < NWORDS; i++) begin : g_wsrc
        if (i < ngates) begin : g_in
            assign w_restart[i] = v_in[i];
        end else begin : g_in_pad
            assign w_restart[i] = '0;
        end
        if (i < ngates_out) begin : g_fold
            assign w_fold[i] = v_tau[i];
        end else begin : g_fold_pad
            assign w_fold[i] = '0;
        end
    end

`ifdef PROVER_COMPUTE_V_SKIP012_EN
    assign skip_start = skip012;
`else
    logic unused_skip012;
    assign unused_skip012 = skip012;
    assign skip_start     = 1'b0;
`endif

    assign n_start = restart ? NW'(ngates_out) : (n_q >> 1);
    assign last    = ({1'b0, k_q} == (n_q - NW'(1)));

    field_mul_add u_mul_add (
        .a (mtau_q),
        .b (w[{k_q, 1'b0}]),
        .c (tau_q),
        .d (w[{k_q, 1'b1}]),
        .y (pair_tau)
    );

    always_ff @(posedge clk) begin
        if (rstb) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // A restart may pre-empt any state; a plain en only advances a finished, foldable round.
    always_comb begin
        state_d = state_q;
        start   = en && (restart || (ready && (n_q > NW'(1))));
        if (start) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:  if (last) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            for (int i = 0; i < NWORDS; i++) w[i] <= '0;
            for (int i = 0; i < ngates_out; i++) begin
                v_0[i]   <= '0;
                v_1[i]   <= '0;
                v_tau[i] <= '0;
            end
            tau_q       <= '0;
            mtau_q      <= '0;
            k_q         <= '0;
            n_q         <= '0;
            skip_q      <= 1'b0;
            ready       <= 1'b0;
            ready_pulse <= 1'b0;
        end else begin
            ready_pulse <= 1'b0;
            if (start) begin
                ready  <= 1'b0;
                k_q    <= '0;
                n_q    <= n_start;
                tau_q  <= tau;
                mtau_q <= m_tau_p1;
                skip_q <= skip_start;
                for (int i = 0; i < NWORDS; i++) w[i] <= restart ? w_restart[i] : w_fold[i];
                for (int i = 0; i < ngates_out; i++) begin
                    if (NW'(i) >= n_start) begin
                        v_tau[i] <= '0;
                        if (!skip_start) begin
                            v_0[i] <= '0;
                            v_1[i] <= '0;
                        end
                    end
                end
            end else if (state_q == ST_RUN) begin
                if (!skip_q) begin
                    v_0[k_q] <= w[{k_q, 1'b0}];
                    v_1[k_q] <= w[{k_q, 1'b1}];
                end
                v_tau[k_q] <= pair_tau;
                k_q        <= k_q + KW'(1);
            end else if (state_q == ST_DONE) begin
                ready       <= 1'b1;
                ready_pulse <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prover_compute_v.sv
// Bench for prover_compute_v: a fixed vector table on a 4-gate instance and
// randomized rounds on a 43-gate instance checked against a modular-arithmetic model.
`timescale 1ns/1ps
module tb_prover_compute_v;
    import prover_compute_v_pkg::*;

    typedef logic [F_NBITS-1:0] fe;
    localparam int NG  = 43;
    localparam int NO  = 32;
    localparam int NG4 = 4;
    localparam int NO4 = 2;
    localparam logic [127:0] Q128 = 128'(F_Q);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstb, en, restart, skip012, ready_pulse, ready;
    fe    tau, mtau;
    fe    v_in [NG];
    fe    v_0 [NO], v_1 [NO], v_tau [NO];

    logic en4, restart4, skip4, ready_pulse4, ready4;
    fe    tau4, mtau4;
    fe    v_in4 [NG4];
    fe    v_04 [NO4], v_14 [NO4], v_tau4 [NO4];

    prover_compute_v #(.ngates(NG)) dut (
        .clk(clk), .rstb(rstb), .en(en), .restart(restart), .skip012(skip012),
        .v_in(v_in), .tau(tau), .m_tau_p1(mtau),
        .ready_pulse(ready_pulse), .ready(ready),
        .v_0(v_0), .v_1(v_1), .v_tau(v_tau)
    );

    prover_compute_v #(.ngates(NG4)) dut4 (
        .clk(clk), .rstb(rstb), .en(en4), .restart(restart4), .skip012(skip4),
        .v_in(v_in4), .tau(tau4), .m_tau_p1(mtau4),
        .ready_pulse(ready_pulse4), .ready(ready4),
        .v_0(v_04), .v_1(v_14), .v_tau(v_tau4)
    );

    int checks   = 0;
    int failures = 0;
    int pulses43 = 0;

    always @(negedge clk) if (ready_pulse === 1'b1) pulses43++;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic fe rnd();
        fe r;
        r = fe'({$urandom, $urandom});
        if (r == F_Q) r = '0;
        return r;
    endfunction

    function automatic fe m_of(input fe t);
        if (t <= fe'(1)) return fe'(1) - t;
        return F_Q - t + fe'(1);
    endfunction

    function automatic fe mac(input fe a, input fe b, input fe c, input fe d);
        logic [127:0] s;
        s = (128'(a) * 128'(b)) % Q128;
        s = s + (128'(c) * 128'(d)) % Q128;
        return fe'(s % Q128);
    endfunction

    // Reference model: W array, pair count, and expected outputs.
    fe  mw [2*NO];
    fe  e0 [NO], e1 [NO], et [NO];
    int mn = 0;

    task automatic model_start(input bit rs, input fe t, input fe m, input bit sk);
        bit hold;
`ifdef PROVER_COMPUTE_V_SKIP012_EN
        hold = sk;
`else
        hold = 1'b0;
        if (sk) hold = 1'b0;
`endif
        if (rs) begin
            for (int i = 0; i < 2*NO; i++) mw[i] = (i < NG) ? v_in[i] : '0;
            mn = NO;
        end else begin
            for (int k = 0; k < mn; k++) mw[k] = et[k];
            mn = mn / 2;
        end
        for (int k = 0; k < NO; k++) begin
            if (k < mn) begin
                if (!hold) begin
                    e0[k] = mw[2*k];
                    e1[k] = mw[2*k+1];
                end
                et[k] = mac(m, mw[2*k], t, mw[2*k+1]);
            end else begin
                if (!hold) begin
                    e0[k] = '0;
                    e1[k] = '0;
                end
                et[k] = '0;
            end
        end
    endtask

    task automatic compare43(input string tag);
        int b0 = -1, b1 = -1, bt = -1;
        for (int k = 0; k < NO; k++) begin
            if (v_0[k] !== e0[k] && b0 < 0) b0 = k;
            if (v_1[k] !== e1[k] && b1 < 0) b1 = k;
            if (v_tau[k] !== et[k] && bt < 0) bt = k;
        end
        chk(b0 < 0, $sformatf("%s_v_0[%0d]", tag, b0), (b0 < 0) ? '0 : 128'(v_0[b0]), (b0 < 0) ? '0 : 128'(e0[b0]));
        chk(b1 < 0, $sformatf("%s_v_1[%0d]", tag, b1), (b1 < 0) ? '0 : 128'(v_1[b1]), (b1 < 0) ? '0 : 128'(e1[b1]));
        chk(bt < 0, $sformatf("%s_v_tau[%0d]", tag, bt), (bt < 0) ? '0 : 128'(v_tau[bt]), (bt < 0) ? '0 : 128'(et[bt]));
    endtask

    function automatic int nz43();
        int n = 0;
        for (int k = 0; k < NO; k++) begin
            if (v_0[k] != '0) n++;
            if (v_1[k] != '0) n++;
            if (v_tau[k] != '0) n++;
        end
        return n;
    endfunction

    // Drive a start request for one edge; tau/m are scrambled afterwards so a
    // design that fails to latch them at round start is exposed.
    task automatic start43(input bit rs, input fe t, input fe m, input bit sk);
        en = 1'b1; restart = rs; tau = t; mtau = m; skip012 = sk;
        @(negedge clk);
        en = 1'b0; restart = 1'b0; skip012 = 1'b0; tau = rnd(); mtau = rnd();
    endtask

    task automatic wait_pulse43(input int exp_cyc, input string tag);
        int cyc = 0;
        int bound;
        bound = (exp_cyc < 0) ? 60 : exp_cyc + 20;
        if (exp_cyc >= 0) chk(ready === 1'b0, {tag, "_ready_low"}, 128'(ready), 0);
        while (ready_pulse !== 1'b1 && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        if (exp_cyc < 0) begin
            chk(cyc == bound, {tag, "_no_pulse"}, cyc, bound);
        end else begin
            chk(cyc == exp_cyc, {tag, "_latency"}, cyc, exp_cyc);
            chk(ready === 1'b1, {tag, "_ready_with_pulse"}, 128'(ready), 1);
            @(negedge clk);
            chk(ready_pulse === 1'b0 && ready === 1'b1, {tag, "_pulse_width"}, {ready_pulse, ready}, 2'b01);
        end
    endtask

    typedef struct {
        bit                     rs;
        fe                      t;
        fe                      m;
        bit                     pulse;
        int                     cyc;
        logic [1:0][F_NBITS-1:0] v0;
        logic [1:0][F_NBITS-1:0] v1;
        logic [1:0][F_NBITS-1:0] vt;
    } row_t;

    function automatic row_t mkrow(input bit rs, input fe t, input fe m, input bit pulse, input int cyc,
                                   input fe a0, input fe a1, input fe b0, input fe b1, input fe c0, input fe c1);
        row_t r;
        r.rs = rs; r.t = t; r.m = m; r.pulse = pulse; r.cyc = cyc;
        r.v0[0] = a0; r.v0[1] = a1;
        r.v1[0] = b0; r.v1[1] = b1;
        r.vt[0] = c0; r.vt[1] = c1;
        return r;
    endfunction

    row_t tbl [5];

    initial begin
        fe  t, m;
        int pbase, bad;

        tbl[0] = mkrow(1, 2, F_Q - 1, 1, 3, 1, 3, 2, 4, 3, 5);
        tbl[1] = mkrow(0, 3, F_Q - 2, 1, 2, 3, 0, 5, 0, 9, 0);
        tbl[2] = mkrow(0, 5, F_Q - 4, 0, 0, 3, 0, 5, 0, 9, 0);
        tbl[3] = mkrow(1, 0, 1,       1, 3, 1, 3, 2, 4, 1, 3);
        tbl[4] = mkrow(0, 1, 0,       1, 2, 1, 0, 3, 0, 3, 0);

        rstb = 1'b1; en = 1'b0; restart = 1'b0; skip012 = 1'b0; tau = '0; mtau = '0;
        en4 = 1'b0; restart4 = 1'b0; skip4 = 1'b0; tau4 = '0; mtau4 = '0;
        for (int i = 0; i < NG; i++) v_in[i] = '0;
        for (int i = 0; i < NG4; i++) v_in4[i] = fe'(i + 1);
        repeat (3) @(negedge clk);

        chk(ready === 1'b0 && ready_pulse === 1'b0, "reset_flags", {ready, ready_pulse}, 0);
        chk(nz43() == 0, "reset_outputs_zero", nz43(), 0);
        chk(ready4 === 1'b0 && v_tau4[0] === '0 && v_04[1] === '0, "reset_dut4", {ready4, v_tau4[0]}, 0);
        rstb = 1'b0;

        // Four-gate vector table
        for (int r = 0; r < 5; r++) begin
            int cyc;
            en4 = 1'b1; restart4 = tbl[r].rs; tau4 = tbl[r].t; mtau4 = tbl[r].m;
            @(negedge clk);
            en4 = 1'b0; restart4 = 1'b0; tau4 = rnd(); mtau4 = rnd();
            cyc = 0;
            while (ready_pulse4 !== 1'b1 && cyc < 10) begin
                @(negedge clk);
                cyc++;
            end
            if (tbl[r].pulse) chk(cyc == tbl[r].cyc, $sformatf("t4_row%0d_latency", r), cyc, tbl[r].cyc);
            else              chk(cyc == 10 && ready4 === 1'b1, $sformatf("t4_row%0d_ignored", r), {cyc, ready4}, {32'd10, 1'b1});
            for (int k = 0; k < NO4; k++) begin
                chk(v_04[k] === tbl[r].v0[k], $sformatf("t4_row%0d_v_0[%0d]", r, k), v_04[k], tbl[r].v0[k]);
                chk(v_14[k] === tbl[r].v1[k], $sformatf("t4_row%0d_v_1[%0d]", r, k), v_14[k], tbl[r].v1[k]);
                chk(v_tau4[k] === tbl[r].vt[k], $sformatf("t4_row%0d_v_tau[%0d]", r, k), v_tau4[k], tbl[r].vt[k]);
            end
            @(negedge clk);
        end

        // Round 0 with tau=0: v_tau copies v_0; tail pairs padded with zero
        for (int i = 0; i < NG; i++) v_in[i] = rnd();
        model_start(1, '0, fe'(1), 0);
        start43(1, '0, fe'(1), 0);
        wait_pulse43(33, "r0");
        compare43("r0");
        bad = 0;
        for (int k = 0; k < NO; k++) if (v_tau[k] !== v_0[k]) bad++;
        chk(bad == 0, "tau0_vtau_eq_v0", bad, 0);
        chk(v_0[21] === v_in[42], "r0_v_0[21]", v_0[21], v_in[42]);
        chk(v_1[21] === '0, "r0_v_1[21]", v_1[21], 0);
        bad = 0;
        for (int k = 22; k < NO; k++) if (v_0[k] !== '0) bad++;
        chk(bad == 0, "r0_v_0_tail_zero", bad, 0);

        // Remaining fold rounds with random challenges
        for (int r = 1; r <= 5; r++) begin
            t = rnd(); m = m_of(t);
            model_start(0, t, m, 0);
            start43(0, t, m, 0);
            wait_pulse43(mn + 1, $sformatf("round%0d", r));
            compare43($sformatf("round%0d", r));
        end
        start43(0, rnd(), rnd(), 0);
        wait_pulse43(-1, "after_final");
        chk(ready === 1'b1, "after_final_ready", ready, 1);
        compare43("after_final");

        // tau=1 selects the odd word of each pair
        for (int i = 0; i < NG; i++) v_in[i] = rnd();
        model_start(1, fe'(1), '0, 0);
        start43(1, fe'(1), '0, 0);
        wait_pulse43(33, "tau1");
        compare43("tau1");
        bad = 0;
        for (int k = 0; k < NO; k++) if (v_tau[k] !== v_1[k]) bad++;
        chk(bad == 0, "tau1_vtau_eq_v1", bad, 0);

        // en without restart while busy is ignored; skip012 raised at round start
        for (int i = 0; i < NG; i++) v_in[i] = rnd();
        t = rnd(); m = m_of(t);
        model_start(1, t, m, 1);
        start43(1, t, m, 1);
        en = 1'b1; tau = rnd(); mtau = rnd();
        @(negedge clk);
        en = 1'b0;
        wait_pulse43(32, "busy_en");
        compare43("busy_en");

        // Restart mid-round: only the second round completes
        pbase = pulses43;
        for (int i = 0; i < NG; i++) v_in[i] = rnd();
        start43(1, rnd(), rnd(), 0);
        repeat (9) @(negedge clk);
        for (int i = 0; i < NG; i++) v_in[i] = rnd();
        t = rnd(); m = m_of(t);
        model_start(1, t, m, 0);
        start43(1, t, m, 0);
        wait_pulse43(33, "abort");
        repeat (40) @(negedge clk);
        chk(pulses43 - pbase == 1, "abort_single_pulse", pulses43 - pbase, 1);
        compare43("abort");

        // Reset mid-round
        start43(1, rnd(), rnd(), 0);
        repeat (10) @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        rstb = 1'b0;
        chk(ready === 1'b0 && ready_pulse === 1'b0, "midrst_flags", {ready, ready_pulse}, 0);
        chk(nz43() == 0, "midrst_outputs_zero", nz43(), 0);
        start43(0, rnd(), rnd(), 0);
        wait_pulse43(-1, "midrst_en");
        chk(ready === 1'b0 && nz43() == 0, "midrst_en_ignored", {ready, 32'(nz43())}, 0);

        // Chain en from ready_pulse through every round
        for (int i = 0; i < NG; i++) v_in[i] = rnd();
        t = rnd(); m = m_of(t);
        model_start(1, t, m, 0);
        for (int r = 1; r <= 5; r++) model_start(0, t, m, 0);
        pbase = pulses43;
        en = 1'b1; restart = 1'b1; tau = t; mtau = m;
        @(negedge clk);
        en = 1'b0; restart = 1'b0;
        for (int c = 0; c < 400; c++) begin
            en = ready_pulse;
            @(negedge clk);
        end
        en = 1'b0;
        chk(pulses43 - pbase == 6, "chain_pulse_count", pulses43 - pbase, 6);
        chk(ready === 1'b1, "chain_ready", ready, 1);
        compare43("chain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
